// File: rtl/edge_event_arbiter.sv
// Edge-event capture with per-channel pending flags and a round-robin grant
// to one shared downstream resource over a valid/ready handshake.
`timescale 1ns/1ps
module edge_event_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter bit EDGE_LEVEL = 1'b1,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_in,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    input  logic               grant_ready,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] dropped,
    input  logic               dropped_clr
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t             state_q, state_d;
    logic               grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] req_prev_q, req_prev_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] dropped_q, dropped_d;

    logic                           handshake;
    logic [NUM_REQ-1:0]             ev;
    logic [NUM_REQ-1:0]             clr;
    logic [NUM_REQ-1:0]             hi_mask;
    logic [NUM_REQ-1:0]             pend_hi;
    logic [NUM_REQ-1:0]             pick_vec;
    logic [NUM_REQ-1:0]             sel_onehot;
    logic [ID_W-1:0]                sel_id;
    logic [ID_W-1:0][NUM_REQ-1:0]   col_mask;

    assign handshake = grant_valid_q && grant_ready;
    assign ev = EDGE_LEVEL ? (req_in & ~req_prev_q) : (~req_in & req_prev_q);

    genvar gi, gb;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ch
            assign clr[gi]     = handshake && (grant_id_q == ID_W'(gi));
            assign hi_mask[gi] = (ID_W'(gi) > rr_ptr_q);
        end
        // One-hot to index: bit gb of the index is the OR of channels whose number has bit gb set.
        for (gb = 0; gb < ID_W; gb++) begin : g_bit
            for (gi = 0; gi < NUM_REQ; gi++) begin : g_col
                assign col_mask[gb][gi] = (((gi >> gb) & 1) == 1);
            end
            assign sel_id[gb] = |(sel_onehot & col_mask[gb]);
        end
    endgenerate

    // Round-robin: prefer channels above the last grant, else wrap to the lowest.
    always_comb begin
        pend_hi    = pending_q & hi_mask;
        pick_vec   = (|pend_hi) ? pend_hi : pending_q;
        sel_onehot = pick_vec & (~pick_vec + NUM_REQ'(1));
    end

    always_comb begin
        req_prev_d = req_in;
        pending_d  = ev | (pending_q & ~clr);
        dropped_d  = (dropped_clr ? '0 : dropped_q) | (ev & pending_q & ~clr);
    end

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_id_d    = sel_id;
                    grant_valid_d = 1'b1;
                    state_d       = OFFER;
                end
            end
            OFFER: begin
                if (handshake) begin
                    rr_ptr_d      = grant_id_q;
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            req_prev_q    <= {NUM_REQ{~EDGE_LEVEL}};
            pending_q     <= '0;
            dropped_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            req_prev_q    <= req_prev_d;
            pending_q     <= pending_d;
            dropped_q     <= dropped_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign pending     = pending_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: behavioural model feeds a grant scoreboard,
// a monitor compares on every handshake; a second falling-edge instance is checked directly.
`timescale 1ns/1ps
module tb_edge_event_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, grant_ready, dropped_clr, grant_valid;
    logic [N-1:0] req_in, pending, dropped;
    logic [1:0]   grant_id;

    logic         rst1_n, rdy1, dclr1, gv1;
    logic [N-1:0] req1, pend1, drop1;
    logic [1:0]   gid1;

    edge_event_arbiter #(.NUM_REQ(N), .EDGE_LEVEL(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_in(req_in),
        .grant_valid(grant_valid), .grant_id(grant_id), .grant_ready(grant_ready),
        .pending(pending), .dropped(dropped), .dropped_clr(dropped_clr)
    );

    edge_event_arbiter #(.NUM_REQ(N), .EDGE_LEVEL(1'b0)) u_dut_fall (
        .clk(clk), .reset_n(rst1_n), .req_in(req1),
        .grant_valid(gv1), .grant_id(gid1), .grant_ready(rdy1),
        .pending(pend1), .dropped(drop1), .dropped_clr(dclr1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending set, sticky drops, one outstanding offer, last-granted pointer.
    bit [N-1:0] m_prev, m_pending, m_dropped;
    bit         m_valid;
    int         m_id, m_rr;
    int         exp_q[$];
    int         seen_q[$];

    function automatic int pick_next(input bit [N-1:0] p, input int rr);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (rr + k) % N;
            if (p[c]) return c;
        end
        return 0;
    endfunction

    function automatic int seen_at(input int i);
        if (i < seen_q.size()) return seen_q[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_pending = '0; m_dropped = '0;
        m_valid = 1'b0; m_id = 0; m_rr = N - 1;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit [N-1:0] ev, clr, oldp;
        bit hs;
        ev   = req_in & ~m_prev;
        hs   = m_valid && grant_ready;
        oldp = m_pending;
        clr  = '0;
        if (hs) clr[m_id] = 1'b1;
        if (m_valid) begin
            if (hs) begin
                m_rr    = m_id;
                m_valid = 1'b0;
            end
        end else if (oldp != 0) begin
            m_id    = pick_next(oldp, m_rr);
            m_valid = 1'b1;
            exp_q.push_back(m_id);
        end
        m_pending = ev | (oldp & ~clr);
        if (dropped_clr) m_dropped = '0;
        m_dropped = m_dropped | (ev & oldp & ~clr);
        m_prev = req_in;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Monitor: samples after the input drive, ahead of the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_n === 1'b1) begin
                chk("grant_valid", grant_valid, m_valid);
                chk("pending", pending, m_pending);
                chk("dropped", dropped, m_dropped);
                if (m_valid) chk("grant_id_held", grant_id, m_id);
                if (grant_valid === 1'b1 && grant_ready === 1'b1) begin
                    seen_q.push_back(int'(grant_id));
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected_grant: got id %0d expected no grant", grant_id);
                    end else begin
                        chk("sb_grant_id", grant_id, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_gv(input int lim);
        int n;
        n = 0;
        while (grant_valid !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_grant_valid", grant_valid, 1);
    endtask

    initial begin
        int base, g, n;
        reset_n = 1'b0; req_in = '0; grant_ready = 1'b1; dropped_clr = 1'b0;
        rst1_n = 1'b0; req1 = '1; rdy1 = 1'b1; dclr1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_grant_valid", grant_valid, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_pending", pending, 0);
        chk("reset_dropped", dropped, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("quiet_no_grants", seen_q.size(), 0);

        // Line held active through reset produces exactly one event.
        reset_n = 1'b0; req_in = 4'b0100;
        repeat (2) @(negedge clk);
        reset_n = 1'b1; base = seen_q.size();
        repeat (8) @(negedge clk);
        chk("held_line_grants", seen_q.size() - base, 1);
        chk("held_line_id", seen_at(base), 2);
        req_in = '0;
        repeat (2) @(negedge clk);

        // Single edge latency.
        req_in = 4'b0010;
        @(negedge clk);
        chk("single_pending_set", pending[1], 1);
        chk("single_not_yet_valid", grant_valid, 0);
        @(negedge clk);
        chk("single_valid", grant_valid, 1);
        chk("single_id", grant_id, 1);
        @(negedge clk);
        chk("single_valid_drop", grant_valid, 0);
        chk("single_pending_clr", pending[1], 0);
        req_in = '0;
        repeat (2) @(negedge clk);

        // All four at once after reset, then 0 and 3 with pointer at 3.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; req_in = 4'b1111; base = seen_q.size();
        repeat (12) @(negedge clk);
        chk("all4_count", seen_q.size() - base, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("all4_order%0d", k), seen_at(base + k), k);
        req_in = '0;
        @(negedge clk);
        req_in = 4'b1001; base = seen_q.size();
        repeat (8) @(negedge clk);
        chk("refire_count", seen_q.size() - base, 2);
        chk("refire_first", seen_at(base), 0);
        chk("refire_second", seen_at(base + 1), 3);

        // Backpressure with a dropped repeat event.
        req_in = '0; grant_ready = 1'b0;
        @(negedge clk);
        req_in = 4'b0100;
        wait_gv(10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_valid", grant_valid, 1);
            chk("stall_id", grant_id, 2);
            if (i == 4) req_in = '0;
            if (i == 8) req_in = 4'b0100;
        end
        chk("stall_pending2", pending[2], 1);
        chk("stall_dropped2", dropped[2], 1);
        grant_ready = 1'b1; base = seen_q.size();
        repeat (5) @(negedge clk);
        chk("stall_one_grant", seen_q.size() - base, 1);
        chk("stall_dropped_kept", dropped[2], 1);
        dropped_clr = 1'b1;
        @(negedge clk);
        dropped_clr = 1'b0;
        @(negedge clk);
        chk("dropped_cleared", dropped, 0);

        // Event coinciding with its own handshake is kept.
        req_in = '0; grant_ready = 1'b0;
        @(negedge clk);
        req_in = 4'b0010;
        wait_gv(10);
        req_in = '0;
        @(negedge clk);
        req_in = 4'b0010; grant_ready = 1'b1; base = seen_q.size();
        @(negedge clk);
        chk("coincide_pending1", pending[1], 1);
        chk("coincide_dropped1", dropped[1], 0);
        repeat (4) @(negedge clk);
        chk("coincide_grants", seen_q.size() - base, 2);
        chk("coincide_second_id", seen_at(base + 1), 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            req_in      = req_in ^ N'($urandom & $urandom);
            grant_ready = ($urandom % 3) != 0;
            dropped_clr = ($urandom % 16) == 0;
        end
        @(negedge clk);
        grant_ready = 1'b1; dropped_clr = 1'b0;
        repeat (20) @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_pending", pending, 0);

        // Falling-edge instance.
        rst1_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("fall_idle_valid", gv1, 0);
        chk("fall_idle_pending", pend1, 0);
        req1 = 4'b1110; g = 0;
        repeat (10) begin
            @(negedge clk);
            if (gv1 === 1'b1) begin
                g++;
                chk("fall_grant_id", gid1, 0);
            end
        end
        chk("fall_grant_count", g, 1);
        req1 = 4'b1111; g = 0;
        repeat (10) begin
            @(negedge clk);
            if (gv1 === 1'b1) g++;
        end
        chk("rise_no_grant", g, 0);
        rdy1 = 1'b0; req1 = 4'b1101; n = 0;
        while (gv1 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("fall_offer_valid", gv1, 1);
        chk("fall_offer_pending", pend1[1], 1);
        #3;
        rst1_n = 1'b0;
        #1;
        chk("async_reset_valid", gv1, 0);
        chk("async_reset_pending", pend1, 0);
        chk("async_reset_id", gid1, 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
